// File: rtl/dmem_sbuf_pkg.sv
// dmem_sbuf_pkg: shared MIPS pipeline constants for the data-memory store buffer
package dmem_sbuf_pkg;
  localparam int SB_DEPTH_DEF = 4;
  localparam int DM_AW_DEF = 6;
  localparam int SB_ENTRY_W = DM_AW_DEF + 32;
endpackage

// File: rtl/dmem_sbuf_sb_fifo.sv
// sb_fifo: store-buffer FIFO with youngest-match forwarding lookup
module sb_fifo
  import dmem_sbuf_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF,
  parameter int AW = DM_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [AW-1:0]          push_idx,
  input  logic [31:0]            push_data,
  input  logic [AW-1:0]          look_idx,
  output logic [AW-1:0]          head_idx,
  output logic [31:0]            head_data,
  output logic                   hit,
  output logic [31:0]            hit_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, slot;
  logic [PW:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0] idx_q [DEPTH];
  logic [AW-1:0] idx_d [DEPTH];
  logic [31:0] dat_q [DEPTH];
  logic [31:0] dat_d [DEPTH];
  // pop retires the head before push fills the tail, so full push+pop reuses the same slot
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d = vld_q;
    idx_d = idx_q;
    dat_d = dat_q;
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (push) begin
      vld_d[tail_q] = 1'b1;
      idx_d[tail_q] = push_idx;
      dat_d[tail_q] = push_data;
      tail_d = tail_q + 1'b1;
    end
    cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end
  // walk oldest to youngest so the last match found is the youngest store
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    slot = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + i[PW-1:0];
      hit_data = (vld_q[slot] && idx_q[slot] == look_idx) ? dat_q[slot] : hit_data;
      hit = hit | (vld_q[slot] && idx_q[slot] == look_idx);
    end
  end
  // state register; entry payloads need no reset because valid bits gate them
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    dat_q <= dat_d;
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end
  assign head_idx = idx_q[head_q];
  assign head_data = dat_q[head_q];
  assign count = cnt_q;
endmodule

// File: rtl/dmem_sbuf.sv
// dmem_sbuf: MEM-stage data RAM fronted by a store buffer that drains on idle or full-store cycles
module dmem_sbuf
  import dmem_sbuf_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int DM_AW = DM_AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_dm,
  input  logic                      re_dm,
  input  logic [31:0]               addr,
  input  logic [31:0]               wd_dm,
  output logic [31:0]               rd_dm,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_empty
);
  logic [31:0] mem_q [2**DM_AW];
  logic [DM_AW-1:0] idx, head_idx;
  logic [31:0] head_data, hit_data;
  logic hit, drain;
  logic unused_addr;
  assign idx = addr[DM_AW+1:2];
  assign unused_addr = ^{addr[31:DM_AW+2], addr[1:0]};
  sb_fifo #(.DEPTH(SB_DEPTH), .AW(DM_AW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(we_dm),
    .pop(drain),
    .push_idx(idx),
    .push_data(wd_dm),
    .look_idx(idx),
    .head_idx(head_idx),
    .head_data(head_data),
    .hit(hit),
    .hit_data(hit_data),
    .count(sb_count)
  );
  // drain on idle cycles, or when a store arrives at a full buffer; loads never drain
  always_comb begin
    drain = (sb_count != '0 && !we_dm && !re_dm) || (sb_count == SB_DEPTH[$clog2(SB_DEPTH):0] && we_dm);
    rd_dm = hit ? hit_data : mem_q[idx];
  end
  // single RAM write port, used only by the drain; reset clears every word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**DM_AW; i++) mem_q[i] <= '0;
    end else if (drain) begin
      mem_q[head_idx] <= head_data;
    end
  end
  assign sb_empty = (sb_count == '0);
endmodule
